// File: rtl/systolic_feeder_pkg.sv
// Shared constants for the systolic operand feeder: array size, phase
// lengths and the FSM state encoding.
package systolic_feeder_pkg;

   localparam int N            = 4;
   localparam int FEED_CYCLES  = 7;
   localparam int DRAIN_CYCLES = 3;
   localparam int CNT_W        = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FEED  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/feeder_bank.sv
// 16-word operand register file: one synchronous write port and N
// combinational read ports (one per array row or column).
module feeder_bank
   import systolic_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         wr_en_i,
   input  logic [3:0]                   wr_addr_i,
   input  logic [DATA_WIDTH-1:0]        wr_data_i,
   input  logic [N-1:0][3:0]            rd_addr_i,
   output logic [N-1:0][DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [N*N];

   // Word storage; cleared by reset so an aborted feed replays zeros.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < N*N; i++) mem_q[i] <= '0;
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Parallel combinational reads, one per stream.
   always_comb begin
      for (int p = 0; p < N; p++) rd_data_o[p] = mem_q[rd_addr_i[p]];
   end

endmodule

// File: rtl/systolic_feeder.sv
// Streams stored A (row-wise, from the left) and B (column-wise, from the
// top) into a 4x4 systolic array with the diagonal skew it needs, then
// waits for the array to drain and pulses done_o.
module systolic_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_en_i,
   input  logic                  wr_sel_i,
   input  logic [3:0]            wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  start_i,
   output logic [DATA_WIDTH-1:0] left_o_0,
   output logic [DATA_WIDTH-1:0] left_o_4,
   output logic [DATA_WIDTH-1:0] left_o_8,
   output logic [DATA_WIDTH-1:0] left_o_12,
   output logic [DATA_WIDTH-1:0] up_o_0,
   output logic [DATA_WIDTH-1:0] up_o_1,
   output logic [DATA_WIDTH-1:0] up_o_2,
   output logic [DATA_WIDTH-1:0] up_o_3,
   output logic                  busy_o,
   output logic                  done_o
);

   logic [1:0]                   state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         idle_w, feed_w;
   logic                         wr_a_w, wr_b_w;
   logic [N-1:0][CNT_W-1:0]      off_w;
   logic [N-1:0]                 vld_w;
   logic [N-1:0][3:0]            a_addr_w, b_addr_w;
   logic [N-1:0][DATA_WIDTH-1:0] a_rd_w, b_rd_w;
   logic [N-1:0][DATA_WIDTH-1:0] left_w, up_w;

   assign idle_w = (state_q == ST_IDLE);
   assign feed_w = (state_q == ST_FEED);

   // Writes are only honoured in IDLE so a running feed sees stable operands.
   assign wr_a_w = wr_en_i & idle_w & ~wr_sel_i;
   assign wr_b_w = wr_en_i & idle_w &  wr_sel_i;

   // Next-state logic; one counter serves both FEED (k) and DRAIN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_FEED;
               cnt_d   = '0;
            end
         end
         ST_FEED: begin
            if (cnt_q == CNT_W'(FEED_CYCLES - 1)) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and counter registers; reset aborts any operation silently.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Skew addressing: stream i carries element (k - i) of its row/column.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         off_w[i]    = cnt_q - CNT_W'(i);
         vld_w[i]    = feed_w && (cnt_q >= CNT_W'(i)) && (off_w[i] <= CNT_W'(N - 1));
         a_addr_w[i] = {2'(i), off_w[i][1:0]};
         b_addr_w[i] = {off_w[i][1:0], 2'(i)};
      end
   end

   feeder_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank_a (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (wr_a_w),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .rd_addr_i (a_addr_w),
      .rd_data_o (a_rd_w)
   );

   feeder_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank_b (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (wr_b_w),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .rd_addr_i (b_addr_w),
      .rd_data_o (b_rd_w)
   );

   // Zero-select: streams outside their diagonal window (or outside FEED) carry 0.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         left_w[i] = vld_w[i] ? a_rd_w[i] : '0;
         up_w[i]   = vld_w[i] ? b_rd_w[i] : '0;
      end
   end

   assign left_o_0  = left_w[0];
   assign left_o_4  = left_w[1];
   assign left_o_8  = left_w[2];
   assign left_o_12 = left_w[3];
   assign up_o_0    = up_w[0];
   assign up_o_1    = up_w[1];
   assign up_o_2    = up_w[2];
   assign up_o_3    = up_w[3];

   assign busy_o = ~idle_w;
   assign done_o = (state_q == ST_DONE);

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: operand word width.
REQ-002 The block SHALL have the localparam N = 4, fixed: array dimension.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_i  in  1  reset; asynchronous, active-high.
REQ-005 wr_en_i  in  1  operand write strobe.
REQ-006 wr_sel_i  in  1  bank select: 0 = matrix A, 1 = matrix B.
REQ-007 wr_addr_i  in  4  element index, row*4+col.
REQ-008 wr_data_i  in  DATA_WIDTH  element value, unsigned.
REQ-009 start_i  in  1  begin one skewed feed of the stored A and B.
REQ-010 left_o_0, left_o_4, left_o_8, left_o_12  out  DATA_WIDTH each  row streams of A for array rows 0..3.
REQ-011 up_o_0, up_o_1, up_o_2, up_o_3  out  DATA_WIDTH each  column streams of B for array columns 0..3.
REQ-012 busy_o  out  1  high in FEED, DRAIN and DONE.
REQ-013 done_o  out  1  one-cycle pulse when the array holds the complete product.

Function
REQ-014 The FSM SHALL have the states IDLE, FEED, DRAIN and DONE.
REQ-015 IDLE→FEED SHALL occur on the edge where start_i=1; FEED SHALL last 7 cycles, with feed counter k=0..6.
REQ-016 FEED→DRAIN SHALL occur after k=6; DRAIN SHALL last 3 cycles; then the FSM SHALL enter DONE for 1 cycle and return to IDLE.
REQ-017 In FEED cycle k, left_o_(4r) SHALL equal A[r][k-r] if 0≤k-r≤3, else 0.
REQ-018 In FEED cycle k, up_o_c SHALL equal B[k-c][c] if 0≤k-c≤3, else 0.
REQ-019 Outside FEED, all left_o_*/up_o_* SHALL be 0.
REQ-020 Latency SHALL be as follows: first nonzero-eligible data in the cycle after the start edge; done_o 11 cycles after the start edge.
REQ-021 done_o SHALL be high only in DONE; busy_o SHALL be low only in IDLE.
REQ-022 Writes SHALL take effect only in IDLE; wr_en_i SHALL be ignored while busy_o=1.
REQ-023 If wr_en_i and start_i occur on the same IDLE edge, the write SHALL land first, and the feed SHALL use the updated value.
REQ-024 start_i SHALL be ignored while busy_o=1; a start asserted during DONE SHALL NOT be queued.
REQ-025 Operand storage SHALL persist across feeds; a second start SHALL replay the same matrices.
REQ-026 Operand values SHALL pass through unmodified, with no arithmetic or width conversion.

Reset
REQ-027 On rst_i=1, the FSM SHALL go to IDLE, k SHALL be 0, and all operand words SHALL be 0, asynchronously.
REQ-028 During and after reset, all stream outputs, busy_o and done_o SHALL be 0.
REQ-029 Reset asserted mid-FEED or mid-DRAIN SHALL abort the operation with no done_o pulse.

Structure
REQ-030 A shared package SHALL hold N, FEED_CYCLES=7, DRAIN_CYCLES=3 and the FSM state encoding.
REQ-031 The block SHALL have one sub-module, feeder_bank: a 16-word register file with a write port and a combinational row/col read, instantiated twice (A, B).
REQ-032 The top level SHALL hold the FSM, the counter and the skew/zero-select muxing.

Verification
REQ-033 Skew: load A = 1..16 row-major and B[i][j] = j+1, then start. Required: left_o_0 = 1,2,3,4,0,0,0; left_o_12 = 0,0,0,13,14,15,16; up_o_1 = 0,2,2,2,2,0,0; up_o_3 = 0,0,0,4,4,4,4; done_o at cycle 11.
REQ-034 Array pairing: same load, outputs driving a 4x4 systolic array. Required: product row 0 = 10,20,30,40 and row 3 = 58,116,174,232.
REQ-035 Busy guards: pulse start_i and write A[0]=99 during FEED k=2. Required: streams unchanged, a single done_o, and A[0] still 1 on the next feed.
REQ-036 Simultaneous events: in IDLE, write A[0]=7 together with start_i. Required: left_o_0 = 7 at k=0.
REQ-037 Reset mid-op: assert rst_i at FEED k=3. Required: all outputs 0 immediately, no done_o, and a subsequent start streams zeros.
REQ-038 Back-to-back: reassert start_i on the cycle after done_o. Required: identical 11-cycle sequence replays.
